// File: rtl/baud_pkg.sv
// Shared definitions for the programmable baud-rate clock generator.
package baud_pkg;

    localparam int ACC_W_DEF = 24;
    localparam longint F_CLK_HZ = 64'sd100_000_000;

    typedef logic [ACC_W_DEF-1:0] inc_t;

    // Increment that yields a 16x-baud tick: round(16 * baud * 2^ACC_W / f_clk).
    function automatic longint inc_for(input longint f_clk, input longint baud);
        longint num;
        num = 64'sd16 * baud * (64'sd1 <<< ACC_W_DEF);
        return (num + (f_clk / 64'sd2)) / f_clk;
    endfunction

    localparam inc_t INC_110     = inc_t'(inc_for(F_CLK_HZ, 64'sd110));
    localparam inc_t INC_300     = inc_t'(inc_for(F_CLK_HZ, 64'sd300));
    localparam inc_t INC_2400    = inc_t'(inc_for(F_CLK_HZ, 64'sd2400));
    localparam inc_t INC_9600    = inc_t'(inc_for(F_CLK_HZ, 64'sd9600));
    localparam inc_t INC_1562500 = inc_t'(inc_for(F_CLK_HZ, 64'sd1562500));

endpackage

// File: rtl/baud_clock_gen_channel.sv
// One rate channel: phase accumulator with shadowed increment, divide chain
// clocked by the accumulator carry, and a retriggerable falling-edge pulse stretcher.
module baud_clock_gen_channel
    import baud_pkg::*;
#(
    parameter int ACC_W        = ACC_W_DEF,
    parameter int DIV_W        = 4,
    parameter int INC_RESET    = 4194304,
    parameter int PULSE_CYCLES = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             inc_wr_i,
    input  logic [ACC_W-1:0] inc_data_i,
    input  logic             strobe_i,
    output logic             tick_o,
    output logic [DIV_W-1:0] div_o,
    output logic             pulse_o
);

    localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_act_q, inc_act_d;
    logic [ACC_W-1:0] inc_shd_q, inc_shd_d;
    logic             pend_q, pend_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_q, tick_d;
    logic             prev_q, prev_d;
    logic [CW-1:0]    pcnt_q, pcnt_d;
    logic             pulse_q, pulse_d;

    logic [ACC_W:0]   sum_s;
    logic             carry_s;
    logic             fall_s;

    // Next-state logic for accumulator, rate shadowing, divider and stretcher.
    always_comb begin
        sum_s   = {1'b0, acc_q} + {1'b0, inc_act_q};
        carry_s = en_i & sum_s[ACC_W];
        fall_s  = prev_q & ~strobe_i;

        // Accumulator and divide chain advance only while enabled.
        if (en_i) begin
            acc_d     = sum_s[ACC_W-1:0];
            tick_d    = sum_s[ACC_W];
            div_cnt_d = div_cnt_q + {{(DIV_W-1){1'b0}}, sum_s[ACC_W]};
        end else begin
            acc_d     = acc_q;
            tick_d    = 1'b0;
            div_cnt_d = div_cnt_q;
        end

        // A pending shadow is promoted on a carry (the carrying add used the
        // old value) or at once while the channel is idle.
        inc_act_d = inc_act_q;
        inc_shd_d = inc_shd_q;
        pend_d    = pend_q;
        if (pend_q && (carry_s || !en_i)) begin
            inc_act_d = inc_shd_q;
            pend_d    = 1'b0;
        end else begin
            pend_d    = pend_q;
        end
        // A fresh write always lands in the shadow; while idle it goes live too.
        if (inc_wr_i) begin
            inc_shd_d = inc_data_i;
            if (!en_i) begin
                inc_act_d = inc_data_i;
                pend_d    = 1'b0;
            end else begin
                pend_d    = 1'b1;
            end
        end else begin
            inc_shd_d = inc_shd_d;
        end

        // Retriggerable stretcher: each fall reloads the full width.
        prev_d = strobe_i;
        if (fall_s) begin
            pcnt_d = CW'(PULSE_CYCLES - 1);
        end else if (pcnt_q != {CW{1'b0}}) begin
            pcnt_d = pcnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            pcnt_d = pcnt_q;
        end
        pulse_d = fall_s | (pcnt_q != {CW{1'b0}});
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= {ACC_W{1'b0}};
            inc_act_q <= ACC_W'(INC_RESET);
            inc_shd_q <= ACC_W'(INC_RESET);
            pend_q    <= 1'b0;
            div_cnt_q <= {DIV_W{1'b0}};
            tick_q    <= 1'b0;
            prev_q    <= 1'b0;
            pcnt_q    <= {CW{1'b0}};
            pulse_q   <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            inc_act_q <= inc_act_d;
            inc_shd_q <= inc_shd_d;
            pend_q    <= pend_d;
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            prev_q    <= prev_d;
            pcnt_q    <= pcnt_d;
            pulse_q   <= pulse_d;
        end
    end

    assign tick_o  = tick_q;
    assign div_o   = div_cnt_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/baud_clock_gen.sv
// Multi-channel programmable baud-rate clock generator: one channel instance
// per rate, outputs packed into flat buses.
module baud_clock_gen
    import baud_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int ACC_W        = ACC_W_DEF,
    parameter int DIV_W        = 4,
    parameter int INC_RESET    = 4194304,
    parameter int PULSE_CYCLES = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       inc_wr,
    input  logic [ACC_W-1:0]          inc_data,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS*DIV_W-1:0] div_q,
    output logic [CHANNELS*DIV_W-1:0] div_qn,
    input  logic [CHANNELS-1:0]       strobe_in,
    output logic [CHANNELS-1:0]       pulse_out
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        baud_clock_gen_channel #(
            .ACC_W        (ACC_W),
            .DIV_W        (DIV_W),
            .INC_RESET    (INC_RESET),
            .PULSE_CYCLES (PULSE_CYCLES)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .en_i       (en[c]),
            .inc_wr_i   (inc_wr[c]),
            .inc_data_i (inc_data),
            .strobe_i   (strobe_in[c]),
            .tick_o     (tick[c]),
            .div_o      (div_q[c*DIV_W +: DIV_W]),
            .pulse_o    (pulse_out[c])
        );
    end

    // Complement taps are a plain inversion of the registered divider.
    assign div_qn = ~div_q;

endmodule

// File: tb/tb_baud_clock_gen.sv
module tb_baud_clock_gen;

    localparam int     NCH   = 2;
    localparam int     INC0  = 4194304;
    localparam longint MOD   = 64'sd16777216;
    localparam int     PW    = 9;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NCH-1:0]   en = '0;
    logic [NCH-1:0]   inc_wr = '0;
    logic [23:0]      inc_data = '0;
    logic [NCH-1:0]   tick;
    logic [NCH*4-1:0] div_q;
    logic [NCH*4-1:0] div_qn;
    logic [NCH-1:0]   strobe_in = '0;
    logic [NCH-1:0]   pulse_out;

    int checks = 0;
    int failures = 0;

    baud_clock_gen #(
        .CHANNELS(NCH), .ACC_W(24), .DIV_W(4), .INC_RESET(INC0), .PULSE_CYCLES(PW)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .inc_wr(inc_wr), .inc_data(inc_data),
        .tick(tick), .div_q(div_q), .div_qn(div_qn),
        .strobe_in(strobe_in), .pulse_out(pulse_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s ch%0d actual=%0d required=%0d at %0t", name, ch, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    longint m_acc  [NCH];
    longint m_inc  [NCH];
    longint m_shd  [NCH];
    bit     m_pend [NCH];
    int     m_div  [NCH];
    bit     m_tick [NCH];
    bit     m_prev [NCH];
    longint m_fall [NCH];
    longint cyc = 0;
    bit     m_ok = 0;
    bit     e_pulse [NCH];

    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (reset) begin
                m_acc[c] = 0; m_inc[c] = INC0; m_shd[c] = INC0; m_pend[c] = 0;
                m_div[c] = 0; m_tick[c] = 0; m_prev[c] = 0; m_fall[c] = -1000;
            end else begin
                longint s;
                bit     cy;
                longint new_inc;
                cy = 0;
                if (en[c]) begin
                    s = m_acc[c] + m_inc[c];
                    cy = (s >= MOD);
                    m_acc[c] = s % MOD;
                    if (cy) m_div[c] = (m_div[c] + 1) % 16;
                end
                m_tick[c] = cy;
                new_inc = m_inc[c];
                if (m_pend[c] && (cy || !en[c])) begin
                    new_inc = m_shd[c];
                    m_pend[c] = 0;
                end
                if (inc_wr[c]) begin
                    m_shd[c] = inc_data;
                    if (!en[c]) begin new_inc = inc_data; m_pend[c] = 0; end
                    else m_pend[c] = 1;
                end
                m_inc[c] = new_inc;
                if (m_prev[c] && !strobe_in[c]) m_fall[c] = cyc;
                m_prev[c] = strobe_in[c];
            end
            e_pulse[c] = (cyc - m_fall[c]) >= 0 && (cyc - m_fall[c]) < PW;
        end
        if (reset) m_ok = 1;
        cyc++;
        #1;
        if (m_ok) begin
            for (int c = 0; c < NCH; c++) begin
                chk("tick",   c, tick[c],          m_tick[c]);
                chk("div_q",  c, div_q[c*4 +: 4],  m_div[c]);
                chk("div_qn", c, div_qn[c*4 +: 4], (~m_div[c]) & 15);
                chk("pulse",  c, pulse_out[c],     e_pulse[c]);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wr(input int c, input logic [23:0] v);
        inc_wr[c] = 1'b1;
        inc_data  = v;
        @(negedge clk);
        inc_wr[c] = 1'b0;
    endtask

    task automatic wait_tick(input int c, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick[c] && n < 64);
    endtask

    task automatic pulse_run(input bit [29:0] pat, output int first, output int cnt);
        first = -1; cnt = 0;
        for (int k = 0; k < 30; k++) begin
            strobe_in[0] = pat[k];
            @(negedge clk);
            if (pulse_out[0]) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        strobe_in[0] = 1'b0;
    endtask

    initial begin
        int n, first, cnt, last, gmin, gmax, tcount;
        bit [29:0] pat;

        repeat (3) @(negedge clk);
        chk("rst_tick",   0, tick,      2'b00);
        chk("rst_div_q",  0, div_q,     8'h00);
        chk("rst_div_qn", 0, div_qn,    8'hFF);
        chk("rst_pulse",  0, pulse_out, 2'b00);
        reset = 1'b0;

        // strobe held low out of reset: no pulse
        repeat (5) @(negedge clk);
        chk("no_spurious_pulse", 0, pulse_out, 2'b00);

        // basic 4-cycle ticking and divider wrap
        en[0] = 1'b1;
        wait_tick(0, n);
        chk("first_tick_latency", 0, n, 4);
        chk("div_after_1", 0, div_q[3:0], 4'd1);
        for (int i = 0; i < 15; i++) begin
            wait_tick(0, n);
            chk("tick_spacing4", 0, n, 4);
        end
        chk("div_wrap", 0, div_q[3:0], 4'd0);

        // rate change mid-period: old spacing until the tick, then new
        wr(0, 24'd8388608);
        wait_tick(0, n);
        chk("old_rate_until_tick", 0, n + 1, 4);
        wait_tick(0, n);
        chk("new_rate2_a", 0, n, 2);
        wait_tick(0, n);
        chk("new_rate2_b", 0, n, 2);
        wr(0, 24'd4194304);
        wait_tick(0, n);
        chk("back_old2", 0, n + 1, 2);
        wait_tick(0, n);
        chk("back_rate4", 0, n, 4);
        // double write before the tick: last write wins
        wr(0, 24'd1048576);
        wr(0, 24'd8388608);
        wait_tick(0, n);
        chk("dbl_old_rate", 0, n + 2, 4);
        wait_tick(0, n);
        chk("dbl_second_wins_a", 0, n, 2);
        wait_tick(0, n);
        chk("dbl_second_wins_b", 0, n, 2);

        // enable drop on channel 1 with a write while disabled
        en[1] = 1'b1;
        wait_tick(1, n);
        chk("ch1_first_tick", 1, n, 4);
        @(negedge clk);
        en[1] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("frozen_no_tick", 1, tick[1], 1'b0);
        end
        wr(1, 24'd8388608);
        repeat (5) begin
            @(negedge clk);
            chk("frozen_no_tick", 1, tick[1], 1'b0);
        end
        chk("frozen_div", 1, div_q[7:4], 4'd1);
        en[1] = 1'b1;
        wait_tick(1, n);
        chk("resume_phase_newinc", 1, n, 2);
        wait_tick(1, n);
        chk("resume_rate2", 1, n, 2);
        chk("ch1_div", 1, div_q[7:4], 4'd3);

        // pulse stretcher: single and retriggered
        pat = 30'b0; pat[0] = 1'b1;
        pulse_run(pat, first, cnt);
        chk("pulse_latency", 0, first, 1);
        chk("pulse_width", 0, cnt, 9);
        pat[5] = 1'b1;
        pulse_run(pat, first, cnt);
        chk("pulse_retrig_width", 0, cnt, 14);

        // reset mid-pulse with a pending write
        strobe_in[1] = 1'b1;
        @(negedge clk);
        strobe_in[1] = 1'b0;
        @(negedge clk);
        chk("pulse_started", 1, pulse_out[1], 1'b1);
        wr(0, 24'd1048576);
        reset = 1'b1;
        en = 2'b00;
        @(negedge clk);
        chk("mid_rst_tick",   0, tick,      2'b00);
        chk("mid_rst_div_q",  0, div_q,     8'h00);
        chk("mid_rst_div_qn", 0, div_qn,    8'hFF);
        chk("mid_rst_pulse",  0, pulse_out, 2'b00);
        reset = 1'b0;
        en[0] = 1'b1;
        wait_tick(0, n);
        chk("post_rst_first", 0, n, 4);
        wait_tick(0, n);
        chk("post_rst_rate", 0, n, 4);

        // fractional rate from zero phase
        reset = 1'b1; en = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        wr(0, 24'd3000000);
        en[0] = 1'b1;
        tcount = 0; last = -1; gmin = 1000; gmax = 0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (tick[0]) begin
                tcount++;
                if (last >= 0) begin
                    if (k - last < gmin) gmin = k - last;
                    if (k - last > gmax) gmax = k - last;
                end
                last = k;
            end
        end
        chk("frac_tick_count", 0, tcount, 178);
        chk("frac_gap_min", 0, gmin, 5);
        chk("frac_gap_max", 0, gmax, 6);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            for (int c = 0; c < NCH; c++) begin
                en[c]     = ($urandom_range(0, 9) != 0);
                inc_wr[c] = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 5) == 0) strobe_in[c] = ~strobe_in[c];
            end
            case ($urandom_range(0, 4))
                0: inc_data = 24'd4194304;
                1: inc_data = 24'd8388608;
                2: inc_data = 24'd3000000;
                3: inc_data = 24'($urandom_range(1048576, 16777215));
                default: inc_data = 24'd0;
            endcase
            @(negedge clk);
        end
        inc_wr = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
